// File: rtl/logic_gate_exerciser.sv
// -----------------------------------------------------------------------------
// logic_gate_exerciser
//
// Run-on-start hardware self test for a 2-input logic_gates block. On an
// accepted start the exerciser walks {a,b} through 00, 01, 10, 11. Each vector
// is held for DWELL settle cycles plus one SAMPLE cycle. In the SAMPLE cycle
// the seven gate outputs are compared against golden values. The results stay
// on the outputs until the next accepted start.
//
// Parameters
//   DWELL  cycles each vector is driven before it is sampled (>= 1)
//   ERR_W  width of err_count (saturating count of mismatching bits)
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      run request, honoured only in IDLE
//   a_out       out  1      drives logic_gates.a (registered)
//   b_out       out  1      drives logic_gates.b (registered)
//   gate_in     in   7      {and,or,nand,nor,not,xor,xnor}, bit6..bit0
//   busy        out  1      high through every DRIVE and SAMPLE cycle
//   done        out  1      one-cycle pulse at end of run
//   pass        out  1      err_count==0 at end of run, held until next start
//   err_count   out  ERR_W  mismatching bit count, saturates at all-ones
//   fail_vec    out  4      bit i set if vector {a,b}=i had any mismatch
//   fail_gates  out  7      OR over vectors of mismatching gate_in bits
// -----------------------------------------------------------------------------
module logic_gate_exerciser #(
  parameter int DWELL = 4,
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic [6:0]       fail_gates
);

  // A zero dwell would sample gate_in in the same cycle the inputs change,
  // before the gate block has had a full cycle to settle.
  if (DWELL < 1) begin : g_dwell_illegal
    $error("logic_gate_exerciser: DWELL must be >= 1");
  end

  // The dwell counter only needs to reach DWELL-1.
  localparam int CNT_W = (DWELL < 2) ? 1 : $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ab_q, ab_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fv_q, fv_d;
  logic [6:0]       fg_q, fg_d;
  logic             pass_q, pass_d;
  logic [6:0]       expected;
  logic [6:0]       mism;

  // Golden response of an ideal gate block, ordered like gate_in.
  function automatic logic [6:0] golden(input logic a, input logic b);
    return {a & b, a | b, ~(a & b), ~(a | b), ~a, a ^ b, ~(a ^ b)};
  endfunction

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Adds inc to acc, clamping at the all-ones value of err_count.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                               input logic [2:0]       inc);
    int sum;
    sum = int'(acc) + int'(inc);
    if (sum > ERR_MAX) begin
      sum = ERR_MAX;
    end
    return ERR_W'(sum);
  endfunction

  assign expected = golden(ab_q[1], ab_q[0]);

  // Four-state compare: an X or Z on gate_in must count as a mismatch rather
  // than silently matching.
  always_comb begin
    mism = '0;
    for (int i = 0; i < 7; i++) begin
      mism[i] = (gate_in[i] !== expected[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fg_d    = fg_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        ab_d = 2'b00;
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 2'd0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = '0;
          fg_d    = '0;
          pass_d  = 1'b0;
        end
      end

      S_DRIVE: begin
        ab_d = vec_q;
        if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SAMPLE: begin
        err_d = sat_add(err_q, popcount7(mism));
        fv_d  = fv_q | ({3'b000, |mism} << vec_q);
        fg_d  = fg_q | mism;
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
          ab_d    = 2'b00;
          pass_d  = (err_d == '0);
        end else begin
          // The next vector is presented on the same edge that leaves SAMPLE,
          // so every DRIVE cycle already sees the new a/b.
          state_d = S_DRIVE;
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          cnt_d   = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ab_d    = 2'b00;
      end

      default: begin
        state_d = S_IDLE;
        ab_d    = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      ab_q    <= 2'b00;
      err_q   <= '0;
      fv_q    <= '0;
      fg_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fg_q    <= fg_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out      = ab_q[1];
  assign b_out      = ab_q[0];
  assign busy       = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fv_q;
  assign fail_gates = fg_q;

endmodule

// File: tb/tb_logic_gate_exerciser.sv
// -----------------------------------------------------------------------------
// Bench for logic_gate_exerciser. There are two instances, each with its own
// behavioural logic_gates model. Instance u1 uses ERR_W=5 and instance u2 uses
// ERR_W=3. A shared fault_mode variable selects the model behaviour:
//   0 = ideal gates
//   1 = xor output stuck at 0
//   2 = all seven outputs inverted
// When a run starts, the end-of-run results expected for that run are queued.
// They are popped and compared in the DONE cycle.
// -----------------------------------------------------------------------------
module tb_logic_gate_exerciser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  int         fault_mode;

  logic       a1, b1, busy1, done1, pass1;
  logic [6:0] g1, fg1;
  logic [4:0] err1;
  logic [3:0] fv1;

  logic       a2, b2, busy2, done2, pass2;
  logic [6:0] g2, fg2;
  logic [2:0] err2;
  logic [3:0] fv2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] err5;
    logic [2:0] err3;
    logic [3:0] fv;
    logic [6:0] fg;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [6:0] gates(input logic a, input logic b, input int m);
    logic [6:0] y;
    y = {a & b, a | b, ~(a & b), ~(a | b), ~a, a ^ b, ~(a ^ b)};
    if (m == 1) y[1] = 1'b0;
    if (m == 2) y = ~y;
    return y;
  endfunction

  assign g1 = gates(a1, b1, fault_mode);
  assign g2 = gates(a2, b2, fault_mode);

  logic_gate_exerciser #(.DWELL(4), .ERR_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_out(a1), .b_out(b1),
    .gate_in(g1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1), .fail_gates(fg1)
  );

  logic_gate_exerciser #(.DWELL(4), .ERR_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_out(a2), .b_out(b2),
    .gate_in(g2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fv2), .fail_gates(fg2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},    {31'd0, a1},    32'd0);
    check({tag, "_b"},    {31'd0, b1},    32'd0);
    check({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    check({tag, "_done"}, {31'd0, done1}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass1}, 32'd0);
    check({tag, "_err"},  {27'd0, err1},  32'd0);
    check({tag, "_fv"},   {28'd0, fv1},   32'd0);
    check({tag, "_fg"},   {25'd0, fg1},   32'd0);
    check({tag, "_err2"}, {29'd0, err2},  32'd0);
    check({tag, "_busy2"},{31'd0, busy2}, 32'd0);
  endtask

  // One complete run with DWELL=4. If hold is set, start stays high through
  // the run and the DONE cycle, so it must not cause a second run.
  task automatic run(input int fm, input bit hold, input exp_t e);
    exp_t got;
    fault_mode = fm;
    sb.push_back(e);
    start = 1'b1;
    tick();                       // edge k accepted the start
    if (!hold) start = 1'b0;
    check("clr_err",  {27'd0, err1},  32'd0);
    check("clr_fv",   {28'd0, fv1},   32'd0);
    check("clr_fg",   {25'd0, fg1},   32'd0);
    check("clr_pass", {31'd0, pass1}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("run_busy", {31'd0, busy1}, 32'd1);
      check("run_ab",   {30'd0, a1, b1}, 32'(i / 5));
      check("run_done", {31'd0, done1}, 32'd0);
      tick();
    end
    // cycle k+21: DONE
    got = sb.pop_front();
    check("done1",     {31'd0, done1}, 32'd1);
    check("done2",     {31'd0, done2}, 32'd1);
    check("done_busy", {31'd0, busy1}, 32'd0);
    check("done_ab",   {30'd0, a1, b1}, 32'd0);
    check("err5",      {27'd0, err1},  {27'd0, got.err5});
    check("err3",      {29'd0, err2},  {29'd0, got.err3});
    check("fail_vec",  {28'd0, fv1},   {28'd0, got.fv});
    check("fail_vec2", {28'd0, fv2},   {28'd0, got.fv});
    check("fail_gts",  {25'd0, fg1},   {25'd0, got.fg});
    check("fail_gts2", {25'd0, fg2},   {25'd0, got.fg});
    check("pass1",     {31'd0, pass1}, {31'd0, got.pass});
    check("pass2",     {31'd0, pass2}, {31'd0, got.pass});
    tick();                       // start, if held, was seen in DONE
    start = 1'b0;
    check("post_done",  {31'd0, done1}, 32'd0);
    check("post_busy",  {31'd0, busy1}, 32'd0);
    check("hold_pass",  {31'd0, pass1}, {31'd0, got.pass});
    tick();
    check("no_restart", {31'd0, busy1}, 32'd0);
    check("hold_err",   {27'd0, err1},  {27'd0, got.err5});
    check("hold_fv",    {28'd0, fv1},   {28'd0, got.fv});
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    fault_mode = 0;
    #12;
    check_all_zero("rst_init");
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", {31'd0, busy1}, 32'd0);

    // Ideal gates: clean pass.
    run(0, 1'b0, '{err5: 5'd0, err3: 3'd0, fv: 4'h0, fg: 7'h00, pass: 1'b1});

    // xor stuck at 0, with start held through the run and the DONE cycle.
    run(1, 1'b1, '{err5: 5'd2, err3: 3'd2, fv: 4'b0110, fg: 7'b0000010, pass: 1'b0});

    // A new start clears the previous failing results.
    run(0, 1'b0, '{err5: 5'd0, err3: 3'd0, fv: 4'h0, fg: 7'h00, pass: 1'b1});

    // All outputs inverted: 28 mismatches; the 3-bit counter saturates.
    run(2, 1'b0, '{err5: 5'd28, err3: 3'd7, fv: 4'hF, fg: 7'h7F, pass: 1'b0});

    // Reset asserted mid-cycle while vec=2 is driven, with errors already counted.
    fault_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("mid_ab",  {30'd0, a1, b1}, 32'd2);
    check("mid_err", {27'd0, err1},   32'd14);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("after_rst_done", {31'd0, done1}, 32'd0);
    end
    check_all_zero("after_rst");

    // A full clean run after the reset.
    run(0, 1'b0, '{err5: 5'd0, err3: 3'd0, fv: 4'h0, fg: 7'h00, pass: 1'b1});

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
